// File: rtl/button_arb_pkg.sv
// Shared types and constants for the push-button command arbiter.
//   arb_state_e    : arbiter FSM state encoding
//   DropCountWidth : width of the saturating lost-event counter
//   WarmupCycles   : cycles after reset release during which edge events
//                    are ignored (the edge-detector flops carry no reset)
package button_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    GAP
  } arb_state_e;

  localparam int DropCountWidth = 8;
  localparam int WarmupCycles   = 2;

endpackage

// File: rtl/edge_detector.sv
// Single-bit edge detector with no reset on its flops.
//   clk_i   : clock
//   sig_i   : raw level input
//   pulse_o : one-cycle pulse, registered relative to sig_i; it is high for
//             the cycle after the first edge that samples the new level
// rising_edge_p selects a rising (1) or falling (0) edge.
module edge_detector #(
  parameter bit rising_edge_p = 1'b1
) (
  input  logic clk_i,
  input  logic sig_i,
  output logic pulse_o
);

  logic sig_q;
  logic sig_qq;

  always_ff @(posedge clk_i) begin
    sig_q  <= sig_i;
    sig_qq <= sig_q;
  end

  assign pulse_o = rising_edge_p ? (sig_q & ~sig_qq) : (~sig_q & sig_qq);

endmodule

// File: rtl/button_cmd_arbiter.sv
// Serialises rising-edge events from num_btn_p push-buttons into a single
// valid/ready command stream, granting pending buttons round-robin.
//   clk_i        : clock
//   reset_i      : asynchronous active-high reset
//   btn_i        : raw button levels
//   ready_i      : consumer ready
//   valid_o      : command offered (registered)
//   idx_o        : index of the granted button (registered)
//   drop_count_o : events lost to an already-pending button, saturating
//
// state | meaning
// IDLE  | nothing offered; grant the next pending button if any
// OFFER | valid_o high, idx_o held until the consumer accepts
// GAP   | pacing after an accept, counter runs down to 1
module button_cmd_arbiter
  import button_arb_pkg::*;
#(
  parameter int num_btn_p = 4,
  parameter int min_gap_p = 0
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [num_btn_p-1:0]         btn_i,
  input  logic                         ready_i,
  output logic                         valid_o,
  output logic [$clog2(num_btn_p)-1:0] idx_o,
  output logic [DropCountWidth-1:0]    drop_count_o
);

  localparam int IdxWidth  = $clog2(num_btn_p);
  localparam int WarmWidth = $clog2(WarmupCycles + 1);
  localparam logic [7:0] GapLoad = 8'(min_gap_p);

  arb_state_e state_q, state_d;
  logic [IdxWidth-1:0] idx_q, idx_d, last_q, last_d;
  logic valid_q;
  logic [7:0] gap_q, gap_d;
  logic [DropCountWidth-1:0] drop_q;
  logic [WarmWidth-1:0] warm_q;
  logic [num_btn_p-1:0] ev_raw, ev, pend_q, clr, pend_rest;
  logic accept;
  logic drop_hit;

  for (genvar i = 0; i < num_btn_p; i++) begin : g_edge
    edge_detector #(.rising_edge_p(1'b1)) u_edge (
      .clk_i  (clk_i),
      .sig_i  (btn_i[i]),
      .pulse_o(ev_raw[i])
    );
  end

  // First set bit of req searching upward from last+1 (wrapping). Scanning
  // from the far end lets the nearest hit overwrite earlier ones.
  function automatic logic [IdxWidth-1:0] rr_pick(input logic [num_btn_p-1:0] req,
                                                  input logic [IdxWidth-1:0]  last);
    int j;
    rr_pick = last;
    for (int k = num_btn_p; k >= 1; k--) begin
      j = (int'(last) + k) % num_btn_p;
      if (req[IdxWidth'(j)]) rr_pick = IdxWidth'(j);
    end
  endfunction

  always_comb begin
    ev        = (warm_q == '0) ? ev_raw : '0;
    accept    = valid_q & ready_i;
    clr       = '0;
    clr[idx_q] = accept;
    pend_rest = pend_q & ~clr;
    // An event on a bit that is being cleared this cycle re-arms it instead
    // of counting as a drop.
    drop_hit  = |(ev & pend_rest);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          idx_d   = rr_pick(pend_q, last_q);
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (accept) begin
          last_d = idx_q;
          if (min_gap_p > 0) begin
            // The IDLE cycle after GAP is part of the gap, so a gap of one
            // goes straight to IDLE.
            gap_d   = GapLoad;
            state_d = (min_gap_p == 1) ? IDLE : GAP;
          end else if (|pend_rest) begin
            idx_d = rr_pick(pend_rest, idx_q);
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        gap_d = gap_q - 8'd1;
        if (gap_q == 8'd2) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= IdxWidth'(num_btn_p - 1);
      valid_q <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= (state_d == OFFER);
      gap_q   <= gap_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pend_q <= '0;
      drop_q <= '0;
      warm_q <= WarmWidth'(WarmupCycles);
    end else begin
      pend_q <= pend_rest | ev;
      if (drop_hit && (drop_q != '1)) drop_q <= drop_q + DropCountWidth'(1);
      if (warm_q != '0) warm_q <= warm_q - WarmWidth'(1);
    end
  end

  assign valid_o      = valid_q;
  assign idx_o        = idx_q;
  assign drop_count_o = drop_q;

endmodule

// File: tb/tb_button_cmd_arbiter.sv
module tb_button_cmd_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  logic [N-1:0] btn_i = '0;
  logic ready_i = 1'b0;
  logic valid0, valid3;
  logic [IW-1:0] idx0, idx3;
  logic [7:0] drop0, drop3;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  button_cmd_arbiter #(.num_btn_p(N), .min_gap_p(0)) dut0 (
    .clk_i(clk_i), .reset_i(reset_i), .btn_i(btn_i), .ready_i(ready_i),
    .valid_o(valid0), .idx_o(idx0), .drop_count_o(drop0)
  );

  button_cmd_arbiter #(.num_btn_p(N), .min_gap_p(3)) dut3 (
    .clk_i(clk_i), .reset_i(reset_i), .btn_i(btn_i), .ready_i(ready_i),
    .valid_o(valid3), .idx_o(idx3), .drop_count_o(drop3)
  );

  // Reference model: [0] mirrors gap 0, [1] mirrors gap 3.
  // "cooldown" counts idle edges that must pass before a new offer may start.
  int           m_gap[2] = '{0, 3};
  logic [N-1:0] m_s1 = '0, m_s0 = '0;
  int           m_warm[2] = '{2, 2};
  logic [N-1:0] m_pend[2] = '{'0, '0};
  int           m_last[2] = '{N-1, N-1};
  bit           m_off[2] = '{0, 0};
  int           m_cur[2] = '{0, 0};
  int           m_cd[2] = '{0, 0};
  int           m_drop[2] = '{0, 0};

  function automatic int pick(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return last;
  endfunction

  task automatic model_reset(input int m);
    m_warm[m] = 2; m_pend[m] = '0; m_last[m] = N - 1;
    m_off[m] = 0; m_cur[m] = 0; m_cd[m] = 0; m_drop[m] = 0;
  endtask

  task automatic model_step(input int m, input logic [N-1:0] ev_in, input logic rdy);
    logic [N-1:0] ev, rest;
    bit acc;
    ev = (m_warm[m] == 0) ? ev_in : '0;
    if (m_warm[m] > 0) m_warm[m]--;
    acc = m_off[m] && rdy;
    rest = m_pend[m];
    if (acc) rest[m_cur[m]] = 1'b0;
    if ((ev & rest) != '0 && m_drop[m] < 255) m_drop[m]++;
    if (m_off[m]) begin
      if (acc) begin
        m_last[m] = m_cur[m];
        if (m_gap[m] > 0) begin
          m_off[m] = 0;
          m_cd[m] = m_gap[m] - 1;
        end else if (rest != '0) begin
          m_cur[m] = pick(rest, m_last[m]);
        end else begin
          m_off[m] = 0;
        end
      end
    end else if (m_cd[m] > 0) begin
      m_cd[m]--;
    end else if (m_pend[m] != '0) begin
      m_cur[m] = pick(m_pend[m], m_last[m]);
      m_off[m] = 1;
    end
    m_pend[m] = rest | ev;
  endtask

  task automatic model_edge();
    logic [N-1:0] ev_in;
    ev_in = m_s1 & ~m_s0;
    for (int m = 0; m < 2; m++) begin
      if (reset_i) model_reset(m);
      else model_step(m, ev_in, ready_i);
    end
    m_s0 = m_s1;
    m_s1 = btn_i;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  task automatic auto_check();
    check("m0_valid", valid0, m_off[0]);
    if (m_off[0]) check("m0_idx", idx0, m_cur[0]);
    check("m0_drop", drop0, m_drop[0]);
    check("m3_valid", valid3, m_off[1]);
    if (m_off[1]) check("m3_idx", idx3, m_cur[1]);
    check("m3_drop", drop3, m_drop[1]);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      model_edge();
      #1;
      auto_check();
    end
  endtask

  task automatic do_reset();
    #2;
    reset_i = 1'b1;
    model_reset(0);
    model_reset(1);
    btn_i = '0;
    ready_i = 1'b0;
    step(3);
    #2;
    reset_i = 1'b0;
    step(3);
  endtask

  typedef struct {
    logic [N-1:0] btn;
    logic         rdy;
    logic         v;
    logic [IW-1:0] idx;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // power-on reset
    step(3);
    check("rst_valid", valid0, 0);
    check("rst_idx", idx0, 0);
    check("rst_drop", drop0, 0);
    check("rst_valid_g3", valid3, 0);
    #2;
    reset_i = 1'b0;
    step(3);

    // single press on button 2, table driven
    for (int i = 0; i < 8; i++) begin
      tbl[i].btn = (i < 5) ? 4'b0100 : 4'b0000;
      tbl[i].rdy = 1'b1;
      tbl[i].v   = (i == 2);
      tbl[i].idx = 2'd2;
    end
    for (int i = 0; i < 8; i++) begin
      btn_i = tbl[i].btn;
      ready_i = tbl[i].rdy;
      step();
      check($sformatf("press_valid_%0d", i), valid0, tbl[i].v);
      if (tbl[i].v) check($sformatf("press_idx_%0d", i), idx0, tbl[i].idx);
      check($sformatf("press_drop_%0d", i), drop0, 0);
    end

    // round robin 0,1,3
    do_reset();
    btn_i = 4'b1011;
    step(3);
    check("rr_first_valid", valid0, 1);
    check("rr_first_idx", idx0, 0);
    step(2);
    check("rr_hold_valid", valid0, 1);
    check("rr_hold_idx", idx0, 0);
    ready_i = 1'b1;
    step();
    check("rr_second_valid", valid0, 1);
    check("rr_second_idx", idx0, 1);
    step();
    check("rr_third_valid", valid0, 1);
    check("rr_third_idx", idx0, 3);
    step();
    check("rr_done_valid", valid0, 0);
    btn_i = '0;

    // gap of 3 on the second instance
    do_reset();
    btn_i = 4'b0011;
    ready_i = 1'b1;
    step(3);
    check("gap_first_valid", valid3, 1);
    check("gap_first_idx", idx3, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("gap_low_%0d", i), valid3, 0);
    end
    step();
    check("gap_second_valid", valid3, 1);
    check("gap_second_idx", idx3, 1);
    step();
    check("gap_after_valid", valid3, 0);
    btn_i = '0;

    // drop counting and saturation
    do_reset();
    btn_i = 4'b0010;
    step(3);
    check("drop_offer_idx", idx0, 1);
    for (int i = 0; i < 10; i++) begin
      btn_i[1] = 1'b0; step();
      btn_i[1] = 1'b1; step();
    end
    step(2);
    check("drop_ten", drop0, 10);
    for (int i = 0; i < 290; i++) begin
      btn_i[1] = 1'b0; step();
      btn_i[1] = 1'b1; step();
    end
    step(2);
    check("drop_sat", drop0, 255);
    check("drop_sat_g3", drop3, 255);
    check("drop_still_valid", valid0, 1);
    check("drop_still_idx", idx0, 1);
    ready_i = 1'b1;
    step();
    check("drop_accepted", valid0, 0);
    step(3);
    check("drop_no_repeat", valid0, 0);
    btn_i = '0;
    ready_i = 1'b0;

    // event coincides with accept of the same button
    do_reset();
    btn_i = 4'b0100;
    step(3);
    check("sim_offer_idx", idx0, 2);
    btn_i = '0;
    step();
    btn_i = 4'b0100;
    step();
    ready_i = 1'b1;
    step();
    check("sim_accept_valid", valid0, 0);
    step();
    check("sim_reoffer_valid", valid0, 1);
    check("sim_reoffer_idx", idx0, 2);
    step();
    check("sim_done_valid", valid0, 0);
    check("sim_drop", drop0, 0);
    btn_i = '0;
    ready_i = 1'b0;

    // asynchronous reset during an offer
    do_reset();
    btn_i = 4'b0001;
    step(3);
    check("rmo_offer_valid", valid0, 1);
    #2;
    reset_i = 1'b1;
    model_reset(0);
    model_reset(1);
    #1;
    check("rmo_async_valid", valid0, 0);
    check("rmo_async_valid_g3", valid3, 0);
    step(2);
    #2;
    reset_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("rmo_quiet_%0d", i), valid0, 0);
    end
    btn_i = '0;

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) btn_i[b] = ~btn_i[b];
      end
      ready_i = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/button_cmd_arbiter.md
# button_cmd_arbiter

Collects rising-edge events from `num_btn_p` board push-buttons and serialises them into a single command stream for the systolic-array control logic. Each button gets its own edge detector and a sticky pending bit. Pending buttons are granted round-robin over a valid/ready handshake. A programmable gap paces consecutive commands, and a saturating counter records events lost to an already-pending button.

## Interface
Parameters:
- `num_btn_p`, default 4: number of buttons, range 2..16.
- `min_gap_p`, default 0: idle cycles forced after each accepted command, range 0..255.

Ports:
- `clk_i`, input, 1: the block's single clock.
- `reset_i`, input, 1: asynchronous, active-high reset.
- `btn_i`, input, `num_btn_p`: raw button levels.
- `ready_i`, input, 1: consumer ready.
- `valid_o`, output, 1: command offered.
- `idx_o`, output, `$clog2(num_btn_p)`: index of the granted button.
- `drop_count_o`, output, 8: number of dropped events, saturating.

## Operation
- **Edge detection.** One rising-edge detector per button produces a one-cycle pulse `ev[i]`.
- **Warm-up after reset.** The edge-detector flops are not reset. For the first 2 cycles after reset deassertion, `ev` is ignored.
- **Pending bits.**
  - `pend[i]` is set on `ev[i]`.
  - `pend[i]` is cleared when a command for `i` is accepted.
  - If the clear and `ev[i]` occur in the same cycle, `pend[i]` stays set and no drop is counted.
- **Drop counting.** If `ev[i]` arrives while `pend[i]` is set and is not being cleared that cycle, `drop_count_o` increments. It saturates at 255. Several simultaneous drops in one cycle count as one.
- **States.**
  - IDLE: `valid_o`=0. If any `pend` bit is set, pick a grant and go to OFFER.
  - OFFER: `valid_o`=1, `idx_o` = grant. On `valid_o & ready_i`:
    - If `min_gap_p` > 0: go to GAP and load the gap counter with `min_gap_p`.
    - Else if another bit is pending: stay in OFFER with the next grant.
    - Else: go to IDLE.
  - GAP: `valid_o`=0. Decrement the counter each cycle. When it reaches 1, go to IDLE.
- **Round-robin grant.** Search starts at `last+1` modulo `num_btn_p` and takes the first set `pend` bit. `last` updates on accept only. After reset, `last` = `num_btn_p-1`, so index 0 has highest priority.
- **Stability while offered.** `idx_o` and `valid_o` are registered and hold stable while `valid_o=1 & ready_i=0`. A newly pending, higher-priority button never pre-empts an offer in progress.
- **Reset values.** `valid_o`=0, `idx_o`=0, `drop_count_o`=0, state=IDLE, `pend`=0, gap counter=0, warm-up counter=2.
- **Reset mid-operation.** Reset mid-offer drops the offer and all pending bits immediately (asynchronous). No command is reissued after reset.

## Timing
- **Event-to-offer latency.** `btn_i` is first sampled high at edge t. `ev` is high between edges t and t+1. `pend` is set at t+1. For an idle block, `valid_o`=1 after edge t+2. Latency is 2 cycles from the first sampling edge.
- **Back-to-back throughput.** With `min_gap_p`=0 and `ready_i` held high, the block issues one command per cycle while pending bits remain.
- **Gap spacing.** With `min_gap_p`=G, `valid_o` is low for exactly G cycles between an accept edge and the next offer. This assumes a bit is pending at GAP exit.
- **Button held high.** Produces exactly one event. Re-arming requires `btn_i` low for at least 1 sampled cycle.

## Structure
- **Shared package `button_arb_pkg`:**
  - State enum `arb_state_e` {IDLE, OFFER, GAP}.
  - `DropCountWidth` = 8.
  - `WarmupCycles` = 2.
- **Sub-module.** The one natural sub-module is the existing `edge_detector` with `rising_edge_p`=1, instantiated `num_btn_p` times in a generate loop.
- **Grant logic.** Round-robin pick and the counters are inline, with no further sub-modules. Target size is about 200 lines.

## Test plan
All scenarios use `num_btn_p`=4.
1. **Single press.** Reset, wait 3 cycles, raise `btn_i[2]` for 5 cycles with `ready_i`=1 and `min_gap_p`=0. Expect exactly one `valid_o` pulse with `idx_o`=2, two cycles after first sample. `drop_count_o` stays 0.
2. **Round-robin order.** With `ready_i`=0, press buttons 3, 1 and 0 in the same cycle, then release `ready_i`. Expect `idx_o` sequence 0, 1, 3 on consecutive cycles.
3. **Gap spacing.** Set `min_gap_p`=3, keep buttons 0 and 1 pending, hold `ready_i`=1. Expect offers for 0 then 1, separated by exactly 3 low `valid_o` cycles.
4. **Drop counting.** With `ready_i`=0 and button 1 pending, pulse `btn_i[1]` low/high 300 times. Expect `drop_count_o`=255 (saturated). After `ready_i`=1, expect a single `idx_o`=1 command.
5. **Simultaneous clear and set.** `ev[2]` arrives on the same edge as the accept of `idx_o`=2. Expect `pend[2]` to remain set, a second `idx_o`=2 offer, and `drop_count_o` unchanged.
6. **Reset mid-offer.** Assert `reset_i` mid-cycle while `valid_o`=1. Expect `valid_o` to fall immediately (asynchronously). After release with `btn_i[0]` held high, expect no spurious command during the warm-up cycles.
